// File: rtl/lmc1992_mixer.sv
// STE Microwire interface and LMC1992 volume/mix emulation.
// Ports: clk/reset; CPU bus din/addr/uds/lds/rw/sel -> dout; busy;
// ym_l/ym_r, ste_l/ste_r sample inputs -> audio_l/audio_r to the DACs.
module lmc1992_mixer #(
  parameter int CLK_DIV = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] din,
  input  logic [4:0]  addr,
  input  logic        uds,
  input  logic        lds,
  input  logic        rw,
  input  logic        sel,
  output logic [15:0] dout,
  input  logic [7:0]  ym_l,
  input  logic [7:0]  ym_r,
  input  logic [7:0]  ste_l,
  input  logic [7:0]  ste_r,
  output logic        busy,
  output logic [7:0]  audio_l,
  output logic [7:0]  audio_r
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [15:0]   mw_data, mw_mask;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    bit_cnt;
  logic [10:0]   lmc;
  logic [3:0]    nbits;
  logic          done;
  logic [1:0]    mix;
  logic [5:0]    master;
  logic [4:0]    left, right;
  logic [3:0]    bass, treble;
  logic [7:0]    gain_l, gain_r;
  logic [7:0]    sat_l, sat_r;

  logic wr, wr_data, wr_mask, tick;
  assign wr      = sel && !rw && !busy;
  assign wr_data = wr && addr == 5'h11;
  assign wr_mask = wr && addr == 5'h12;
  assign tick    = busy && tick_cnt == TW'(CLK_DIV - 1);

  always_comb begin
    dout = '0;
    if (sel && rw && addr == 5'h11) dout = mw_data;
    else if (sel && rw && addr == 5'h12) dout = mw_mask;
  end

  // Register writes and the 16-tick serial shift; the rotation returns
  // both registers to their original values at the end of a transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      mw_data  <= '0;
      mw_mask  <= '0;
      busy     <= 1'b0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      lmc      <= '0;
      nbits    <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_data && uds) mw_data[15:8] <= din[15:8];
      if (wr_data && lds) mw_data[7:0]  <= din[7:0];
      if (wr_mask && uds) mw_mask[15:8] <= din[15:8];
      if (wr_mask && lds) mw_mask[7:0]  <= din[7:0];
      if (wr_data && (uds || lds)) begin
        busy     <= 1'b1;
        tick_cnt <= '0;
        bit_cnt  <= '0;
        lmc      <= '0;
        nbits    <= '0;
      end else if (tick) begin
        tick_cnt <= '0;
        if (mw_mask[15]) begin
          lmc <= {lmc[9:0], mw_data[15]};
          if (nbits != 4'd11) nbits <= nbits + 4'd1;
        end
        mw_data <= {mw_data[14:0], mw_data[15]};
        mw_mask <= {mw_mask[14:0], mw_mask[15]};
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd15) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (busy) begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

  logic [2:0] cmd;
  logic [5:0] cdat;
  logic       cmd_ok;
  assign cmd    = lmc[8:6];
  assign cdat   = lmc[5:0];
  assign cmd_ok = done && nbits == 4'd11 && lmc[10:9] == 2'b10;

  always_ff @(posedge clk) begin
    if (reset) begin
      mix    <= 2'b01;
      master <= 6'd40;
      left   <= 5'd20;
      right  <= 5'd20;
      bass   <= 4'd6;
      treble <= 4'd6;
    end else if (cmd_ok) begin
      unique case (1'b1)
        cmd == 3'b000: mix    <= cdat[1:0];
        cmd == 3'b001: bass   <= cdat[3:0];
        cmd == 3'b010: treble <= cdat[3:0];
        cmd == 3'b011: master <= (cdat > 6'd40) ? 6'd40 : cdat;
        cmd == 3'b100: right  <= (cdat[4:0] > 5'd20) ? 5'd20 : cdat[4:0];
        cmd == 3'b101: left   <= (cdat[4:0] > 5'd20) ? 5'd20 : cdat[4:0];
        default: ;
      endcase
    end
  end

  // round(255 * 10^(-s/10)); anything past 24 steps is silence.
  function automatic logic [7:0] atten(input logic [6:0] s);
    unique case (s)
      7'd0:  atten = 8'd255;
      7'd1:  atten = 8'd203;
      7'd2:  atten = 8'd161;
      7'd3:  atten = 8'd128;
      7'd4:  atten = 8'd102;
      7'd5:  atten = 8'd81;
      7'd6:  atten = 8'd64;
      7'd7:  atten = 8'd51;
      7'd8:  atten = 8'd40;
      7'd9:  atten = 8'd32;
      7'd10: atten = 8'd26;
      7'd11: atten = 8'd20;
      7'd12: atten = 8'd16;
      7'd13: atten = 8'd13;
      7'd14: atten = 8'd10;
      7'd15: atten = 8'd8;
      7'd16: atten = 8'd6;
      7'd17: atten = 8'd5;
      7'd18: atten = 8'd4;
      7'd19: atten = 8'd3;
      7'd20: atten = 8'd3;
      7'd21: atten = 8'd2;
      7'd22: atten = 8'd2;
      7'd23: atten = 8'd1;
      7'd24: atten = 8'd1;
      default: atten = 8'd0;
    endcase
  endfunction

  logic [6:0] steps_l, steps_r;
  assign steps_l = 7'(6'd40 - master) + 7'(5'd20 - left);
  assign steps_r = 7'(6'd40 - master) + 7'(5'd20 - right);

  function automatic logic [7:0] ym_term(input logic [1:0] m,
                                         input logic [7:0] y);
    unique case (m)
      2'b00:   ym_term = y >> 2;
      2'b10:   ym_term = 8'd0;
      default: ym_term = y;
    endcase
  endfunction

  logic [8:0]  sum_l, sum_r;
  logic [15:0] prod_l, prod_r;
  assign sum_l  = {1'b0, ym_term(mix, ym_l)} + {1'b0, ste_l};
  assign sum_r  = {1'b0, ym_term(mix, ym_r)} + {1'b0, ste_r};
  assign prod_l = sat_l * gain_l;
  assign prod_r = sat_r * gain_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      gain_l  <= 8'd255;
      gain_r  <= 8'd255;
      sat_l   <= '0;
      sat_r   <= '0;
      audio_l <= '0;
      audio_r <= '0;
    end else begin
      gain_l  <= atten(steps_l);
      gain_r  <= atten(steps_r);
      sat_l   <= sum_l[8] ? 8'hFF : sum_l[7:0];
      sat_r   <= sum_r[8] ? 8'hFF : sum_r[7:0];
      audio_l <= prod_l[15:8];
      audio_r <= prod_r[15:8];
    end
  end

endmodule

// File: tb/tb_lmc1992_mixer.sv
// Scoreboard bench for lmc1992_mixer: directed Microwire transfers
// and audio vectors with hand-computed expectations.
module tb_lmc1992_mixer;

  logic        clk = 0, reset = 1;
  logic [15:0] din = 0, dout;
  logic [4:0]  addr = 0;
  logic        uds = 0, lds = 0, rw = 1, sel = 0;
  logic [7:0]  ym_l = 0, ym_r = 0, ste_l = 0, ste_r = 0;
  logic        busy;
  logic [7:0]  audio_l, audio_r;

  lmc1992_mixer #(.CLK_DIV(8)) dut (
    .clk(clk), .reset(reset), .din(din), .addr(addr), .uds(uds),
    .lds(lds), .rw(rw), .sel(sel), .dout(dout), .ym_l(ym_l),
    .ym_r(ym_r), .ste_l(ste_l), .ste_r(ste_r), .busy(busy),
    .audio_l(audio_l), .audio_r(audio_r)
  );

  always #5 clk = ~clk;

  localparam int K_RD = 0, K_BUSY = 1, K_NOW = 2, K_AUD = 3;
  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       name;
  } item_t;
  item_t sb[$];

  int nvec = 0, nmiss = 0, cyc = 0;
  logic now_v = 0, au_v = 0, a1 = 0, a2 = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    a1  <= au_v;
    a2  <= a1;
  end

  always @(negedge clk) begin
    if (now_v || a2) begin
      item_t it;
      logic [15:0] act;
      if (sb.size() == 0) begin
        nmiss++;
        $display("FAIL scoreboard: output with no expected entry");
      end else begin
        it = sb.pop_front();
        case (it.kind)
          K_RD:    act = dout;
          K_BUSY:  act = {15'd0, busy};
          default: act = {audio_l, audio_r};
        endcase
        nvec++;
        if (act !== it.exp) begin
          nmiss++;
          $display("FAIL %s: got %h, need %h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [15:0] d,
                        output int w);
    sel = 1; rw = 0; addr = a; din = d; uds = 1; lds = 1;
    step();
    w = cyc;
    sel = 0; rw = 1; uds = 0; lds = 0;
  endtask

  task automatic chk_rd(input logic [4:0] a, input logic [15:0] e,
                        input string nm);
    sel = 1; rw = 1; addr = a;
    sb.push_back('{K_RD, e, nm});
    now_v = 1;
    step();
    now_v = 0; sel = 0;
  endtask

  task automatic chk_busy(input logic e, input string nm);
    sb.push_back('{K_BUSY, {15'd0, e}, nm});
    now_v = 1;
    step();
    now_v = 0;
  endtask

  task automatic chk_now(input logic [15:0] e, input string nm);
    sb.push_back('{K_NOW, e, nm});
    now_v = 1;
    step();
    now_v = 0;
  endtask

  task automatic chk_aud(input logic [7:0] y, input logic [7:0] s,
                         input logic [15:0] e, input string nm);
    ym_l = y; ym_r = y; ste_l = s; ste_r = s;
    sb.push_back('{K_AUD, e, nm});
    au_v = 1;
    step();
    au_v = 0;
    repeat (3) step();
  endtask

  task automatic xfer(input logic [15:0] m, input logic [15:0] d,
                      output int w);
    int wm;
    wr_reg(5'h12, m, wm);
    wr_reg(5'h11, d, w);
  endtask

  task automatic cmd(input logic [15:0] d);
    int w;
    xfer(16'h07FF, d, w);
    wait_to(w + 131);
  endtask

  initial begin
    int w, t;
    repeat (3) step();
    reset = 0;

    chk_busy(0, "rst_busy");
    chk_rd(5'h11, 16'h0000, "rst_data");
    chk_rd(5'h12, 16'h0000, "rst_mask");
    chk_aud(100, 50, 16'h9595, "rst_audio");

    wr_reg(5'h12, 16'h07FF, t);
    chk_busy(0, "mask_no_start");
    chk_rd(5'h12, 16'h07FF, "mask_rd");
    wr_reg(5'h11, 16'h04E5, w);
    chk_busy(1, "busy_rise");
    wait_to(w + 8);
    chk_rd(5'h12, 16'h0FFE, "mask_tick1");
    chk_rd(5'h11, 16'h09CA, "data_tick1");
    wait_to(w + 127);
    chk_busy(1, "busy_127");
    chk_busy(0, "busy_128");
    chk_rd(5'h12, 16'h07FF, "mask_end");
    chk_rd(5'h11, 16'h04E5, "data_end");
    wait_to(w + 131);
    chk_aud(100, 50, 16'h4B4B, "master37");

    cmd(16'h04E8);
    chk_aud(100, 50, 16'h9595, "master40");
    cmd(16'h0541);
    chk_aud(100, 50, 16'h0195, "left1");
    cmd(16'h0554);
    chk_aud(100, 50, 16'h9595, "left20");

    cmd(16'h0402);
    chk_aud(100, 50, 16'h3131, "mix10");
    cmd(16'h0400);
    chk_aud(200, 0, 16'h3131, "mix00");
    chk_aud(200, 200, 16'hF9F9, "mix00_sum");
    cmd(16'h0401);
    chk_aud(200, 200, 16'hFEFE, "mix01_sat");

    cmd(16'h050A);
    chk_aud(100, 50, 16'h950F, "right10");
    cmd(16'h051F);
    chk_aud(100, 50, 16'h9595, "right_clamp");
    cmd(16'h04E5);
    chk_aud(100, 50, 16'h4B4B, "master37b");
    cmd(16'h04FF);
    chk_aud(100, 50, 16'h9595, "master_clamp");

    xfer(16'h07FF, 16'h00E5, w);
    wait_to(w + 39);
    wr_reg(5'h11, 16'h04E8, t);
    chk_rd(5'h11, 16'h1CA0, "busy_write_ign");
    chk_busy(1, "busy_mid");
    wait_to(w + 131);
    chk_rd(5'h11, 16'h00E5, "data_after_ign");
    chk_aud(100, 50, 16'h9595, "bad_addr");

    xfer(16'h03FF, 16'h04E5, w);
    wait_to(w + 131);
    chk_aud(100, 50, 16'h9595, "short_cmd");
    xfer(16'hFFFF, 16'h04E5, w);
    wait_to(w + 131);
    chk_aud(100, 50, 16'h4B4B, "long_mask");

    xfer(16'h07FF, 16'h0541, w);
    wait_to(w + 63);
    reset = 1;
    step();
    reset = 0;
    chk_now(16'h0000, "rst_mid_audio");
    chk_busy(0, "rst_mid_busy");
    chk_rd(5'h11, 16'h0000, "rst_mid_data");
    chk_rd(5'h12, 16'h0000, "rst_mid_mask");
    chk_aud(100, 50, 16'h9595, "rst_defaults");
    wait_to(w + 140);
    chk_aud(100, 50, 16'h9595, "rst_no_cmd");

    repeat (4) step();
    if (sb.size() != 0) begin
      nmiss++;
      $display("FAIL drain: got %0d pending, need 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
